// File: rtl/wb_cache_ctrl_if.sv
// Purpose : bundles the CPU-side request/ready port, flush handshake, memory
//           word-transfer port and statistics counters of wb_cache_ctrl.
// Ports   : slave = cache side (drives cpu_rdata/ready, mem_* requests, counters);
//           master = requester + memory side (drives cpu_* requests, flush, mem_rdata/ack).
interface wb_cache_ctrl_if #(
    parameter int ADDR_W = 20
);
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [31:0]       cpu_wdata;
    logic [31:0]       cpu_rdata;
    logic              cpu_ready;
    logic              flush;
    logic              flush_done;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;
    logic              mem_ack;
    logic [31:0]       hit_count;
    logic [31:0]       miss_count;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata, flush, mem_rdata, mem_ack,
        output cpu_rdata, cpu_ready, flush_done, mem_req, mem_we, mem_addr,
               mem_wdata, hit_count, miss_count
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata, flush, mem_rdata, mem_ack,
        input  cpu_rdata, cpu_ready, flush_done, mem_req, mem_we, mem_addr,
               mem_wdata, hit_count, miss_count
    );
endinterface

// File: rtl/wb_cache_ctrl.sv
// Purpose : direct-mapped, write-back, write-allocate cache controller between one
//           pipeline memory port and main memory, with flush and hit/miss counters.
// Latency : hit -> cpu_ready two cycles after the request is sampled; a miss adds an
//           optional dirty write-back burst plus a refill burst, one word per mem_ack.
// Backpressure: the requester holds cpu_req until the one-cycle cpu_ready pulse; the
//           memory side stalls each word by withholding mem_ack (mem_req held meanwhile).
// Ports   : clock, reset (sync, active-high), bus (wb_cache_ctrl_if.slave).
module wb_cache_ctrl #(
    parameter int ADDR_W         = 20,
    parameter int NUM_LINES      = 64,
    parameter int WORDS_PER_LINE = 4
) (
    input  logic           clock,
    input  logic           reset,
    wb_cache_ctrl_if.slave bus
);
    localparam int OFF   = $clog2(WORDS_PER_LINE);
    localparam int IDX   = $clog2(NUM_LINES);
    localparam int TAG_W = ADDR_W - OFF - IDX - 2;
    localparam int WC_W  = (OFF > 0) ? OFF : 1;
    localparam int DI_W  = IDX + OFF;
    localparam logic [WC_W-1:0] LAST_WORD = WC_W'(WORDS_PER_LINE - 1);
    localparam logic [IDX-1:0]  LAST_LINE = IDX'(NUM_LINES - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOOKUP = 3'd1;
    localparam logic [2:0] S_WB     = 3'd2;
    localparam logic [2:0] S_FILL   = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;
    localparam logic [2:0] S_FLUSH  = 3'd5;

    logic [2:0]        state;
    logic [ADDR_W-1:0] req_addr;
    logic              req_we;
    logic [31:0]       req_wdata;
    logic              refilled;   // current request already went through a refill
    logic              flushing;   // WB burst belongs to a flush scan, not a miss
    logic [IDX-1:0]    line_idx;   // line being written back / filled / scanned
    logic [WC_W-1:0]   wcnt;

    logic [NUM_LINES-1:0] valid;
    logic [NUM_LINES-1:0] dirty;
    logic [TAG_W-1:0]     tag_arr  [NUM_LINES];
    logic [31:0]          data_arr [NUM_LINES*WORDS_PER_LINE];

    logic [31:0]       cpu_rdata_q;
    logic              cpu_ready_q;
    logic              flush_done_q;
    logic              mem_req_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [31:0]       mem_wdata_q;
    logic [31:0]       hit_cnt;
    logic [31:0]       miss_cnt;

    logic [IDX-1:0]    req_idx;
    logic [TAG_W-1:0]  req_tag;
    logic [WC_W-1:0]   req_word;
    logic              hit;
    logic              last_word;
    logic [WC_W-1:0]   wnext;

    assign req_idx   = IDX'(req_addr >> (OFF + 2));
    assign req_tag   = TAG_W'(req_addr >> (OFF + IDX + 2));
    assign req_word  = WC_W'((req_addr >> 2) & ADDR_W'(WORDS_PER_LINE - 1));
    assign hit       = valid[req_idx] && (tag_arr[req_idx] == req_tag);
    assign last_word = (wcnt == LAST_WORD);
    assign wnext     = wcnt + WC_W'(1);

    function automatic logic [ADDR_W-1:0] line_addr(input logic [TAG_W-1:0] t,
                                                    input logic [IDX-1:0]   i,
                                                    input logic [WC_W-1:0]  w);
        return (ADDR_W'(t) << (OFF + IDX + 2)) | (ADDR_W'(i) << (OFF + 2)) | (ADDR_W'(w) << 2);
    endfunction

    function automatic logic [DI_W-1:0] dix(input logic [IDX-1:0] i, input logic [WC_W-1:0] w);
        return (DI_W'(i) << OFF) | DI_W'(w);
    endfunction

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= S_IDLE;
            req_addr     <= '0;
            req_we       <= 1'b0;
            req_wdata    <= '0;
            refilled     <= 1'b0;
            flushing     <= 1'b0;
            line_idx     <= '0;
            wcnt         <= '0;
            valid        <= '0;
            dirty        <= '0;
            cpu_rdata_q  <= '0;
            cpu_ready_q  <= 1'b0;
            flush_done_q <= 1'b0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            hit_cnt      <= '0;
            miss_cnt     <= '0;
        end else begin
            cpu_ready_q  <= 1'b0;
            flush_done_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.flush) begin
                        state    <= S_FLUSH;
                        flushing <= 1'b1;
                        line_idx <= '0;
                    end else if (bus.cpu_req) begin
                        req_addr  <= bus.cpu_addr;
                        req_we    <= bus.cpu_we;
                        req_wdata <= bus.cpu_wdata;
                        refilled  <= 1'b0;
                        state     <= S_LOOKUP;
                    end
                end
                S_LOOKUP: begin
                    if (hit) begin
                        if (!req_we) cpu_rdata_q <= data_arr[dix(req_idx, req_word)];
                        else         dirty[req_idx] <= 1'b1;
                        if (!refilled) hit_cnt <= hit_cnt + 32'd1;
                        cpu_ready_q <= 1'b1;
                        state       <= S_DONE;
                    end else begin
                        miss_cnt  <= miss_cnt + 32'd1;
                        line_idx  <= req_idx;
                        wcnt      <= '0;
                        mem_req_q <= 1'b1;
                        if (valid[req_idx] && dirty[req_idx]) begin
                            state       <= S_WB;
                            mem_we_q    <= 1'b1;
                            mem_addr_q  <= line_addr(tag_arr[req_idx], req_idx, '0);
                            mem_wdata_q <= data_arr[dix(req_idx, '0)];
                        end else begin
                            state      <= S_FILL;
                            mem_we_q   <= 1'b0;
                            mem_addr_q <= line_addr(req_tag, req_idx, '0);
                        end
                    end
                end
                S_WB: begin
                    if (bus.mem_ack) begin
                        if (!last_word) begin
                            wcnt        <= wnext;
                            mem_addr_q  <= line_addr(tag_arr[line_idx], line_idx, wnext);
                            mem_wdata_q <= data_arr[dix(line_idx, wnext)];
                        end else begin
                            wcnt <= '0;
                            if (flushing) begin
                                // line stays valid, only its dirty copy is now in memory
                                dirty[line_idx] <= 1'b0;
                                mem_req_q       <= 1'b0;
                                mem_we_q        <= 1'b0;
                                if (line_idx == LAST_LINE) begin
                                    flush_done_q <= 1'b1;
                                    flushing     <= 1'b0;
                                    state        <= S_IDLE;
                                end else begin
                                    line_idx <= line_idx + IDX'(1);
                                    state    <= S_FLUSH;
                                end
                            end else begin
                                // mem_req stays high straight into the refill burst
                                state      <= S_FILL;
                                mem_we_q   <= 1'b0;
                                mem_addr_q <= line_addr(req_tag, line_idx, '0);
                            end
                        end
                    end
                end
                S_FILL: begin
                    if (bus.mem_ack) begin
                        if (!last_word) begin
                            wcnt       <= wnext;
                            mem_addr_q <= line_addr(req_tag, line_idx, wnext);
                        end else begin
                            wcnt            <= '0;
                            mem_req_q       <= 1'b0;
                            valid[line_idx] <= 1'b1;
                            dirty[line_idx] <= 1'b0;
                            refilled        <= 1'b1;
                            state           <= S_LOOKUP;
                        end
                    end
                end
                S_DONE: state <= S_IDLE;
                S_FLUSH: begin
                    if (valid[line_idx] && dirty[line_idx]) begin
                        state       <= S_WB;
                        wcnt        <= '0;
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= 1'b1;
                        mem_addr_q  <= line_addr(tag_arr[line_idx], line_idx, '0);
                        mem_wdata_q <= data_arr[dix(line_idx, '0)];
                    end else if (line_idx == LAST_LINE) begin
                        flush_done_q <= 1'b1;
                        flushing     <= 1'b0;
                        state        <= S_IDLE;
                    end else begin
                        line_idx <= line_idx + IDX'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Tag/data storage carries no reset so it can map onto RAM; valid/dirty gate it.
    always_ff @(posedge clock) begin
        if (!reset) begin
            if (state == S_LOOKUP && hit && req_we)
                data_arr[dix(req_idx, req_word)] <= req_wdata;
            if (state == S_FILL && bus.mem_ack) begin
                data_arr[dix(line_idx, wcnt)] <= bus.mem_rdata;
                if (last_word) tag_arr[line_idx] <= req_tag;
            end
        end
    end

    assign bus.cpu_rdata  = cpu_rdata_q;
    assign bus.cpu_ready  = cpu_ready_q;
    assign bus.flush_done = flush_done_q;
    assign bus.mem_req    = mem_req_q;
    assign bus.mem_we     = mem_we_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wdata  = mem_wdata_q;
    assign bus.hit_count  = hit_cnt;
    assign bus.miss_count = miss_cnt;
endmodule

// File: tb/tb_wb_cache_ctrl.sv
// Purpose : self-checking bench for wb_cache_ctrl: directed scenarios plus random
//           accesses/flushes against a transparent-memory reference model.
// Ports   : none (top); drives the interface master side and models main memory
//           with an ack two cycles into each word request.
module tb_wb_cache_ctrl;
    localparam int ADDR_W = 20;
    localparam int NL     = 64;
    localparam int WPL    = 4;
    localparam int LB     = WPL * 4;
    localparam int SPAN   = LB * NL;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    wb_cache_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

    wb_cache_ctrl #(.ADDR_W(ADDR_W), .NUM_LINES(NL), .WORDS_PER_LINE(WPL)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
    } xfer_t;

    xfer_t       obs_q[$];
    xfer_t       exp_q[$];
    logic [31:0] backing [int];   // what main memory holds
    logic [31:0] golden  [int];   // what the CPU must observe
    int          errors = 0;
    int          checks = 0;
    int          mcnt   = 0;

    int m_tag   [NL];
    bit m_valid [NL];
    bit m_dirty [NL];
    int m_hits   = 0;
    int m_misses = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] init_word(input int a);
        return (a * 32'h9E3779B1) ^ 32'h5A5AC3C3;
    endfunction

    function automatic logic [31:0] back_rd(input int a);
        return backing.exists(a) ? backing[a] : init_word(a);
    endfunction

    function automatic logic [31:0] gold_rd(input int a);
        return golden.exists(a) ? golden[a] : init_word(a);
    endfunction

    // Main memory: ack in the second cycle of each word request.
    always @(negedge clock) begin
        if (reset || !bus.mem_req) begin
            bus.mem_ack = 1'b0;
            mcnt = 0;
        end else if (bus.mem_ack) begin
            bus.mem_ack = 1'b0;
            mcnt = 1;
        end else begin
            mcnt++;
            if (mcnt >= 2) begin
                xfer_t x;
                x.we   = bus.mem_we;
                x.addr = bus.mem_addr;
                x.data = bus.mem_we ? bus.mem_wdata : back_rd(int'(bus.mem_addr));
                if (bus.mem_we) backing[int'(bus.mem_addr)] = bus.mem_wdata;
                else            bus.mem_rdata = x.data;
                obs_q.push_back(x);
                bus.mem_ack = 1'b1;
            end
        end
    end

    task automatic push_line(input bit we, input int base);
        xfer_t x;
        for (int w = 0; w < WPL; w++) begin
            x.we   = we;
            x.addr = ADDR_W'(base + 4 * w);
            x.data = we ? gold_rd(base + 4 * w) : 32'h0;
            exp_q.push_back(x);
        end
    endtask

    task automatic model_access(input bit we, input int a, input logic [31:0] wd,
                                output bit was_hit, output logic [31:0] rd);
        int i, t;
        a = a & ~3;
        i = (a / LB) % NL;
        t = a / SPAN;
        was_hit = m_valid[i] && (m_tag[i] == t);
        if (was_hit) m_hits++;
        else begin
            m_misses++;
            if (m_valid[i] && m_dirty[i]) push_line(1'b1, m_tag[i] * SPAN + i * LB);
            push_line(1'b0, t * SPAN + i * LB);
            m_valid[i] = 1'b1;
            m_tag[i]   = t;
            m_dirty[i] = 1'b0;
        end
        if (we) begin
            golden[a]  = wd;
            m_dirty[i] = 1'b1;
        end
        rd = gold_rd(a);
    endtask

    task automatic model_flush();
        for (int i = 0; i < NL; i++) begin
            if (m_valid[i] && m_dirty[i]) begin
                push_line(1'b1, m_tag[i] * SPAN + i * LB);
                m_dirty[i] = 1'b0;
            end
        end
    endtask

    task automatic model_reset();
        golden.delete();
        foreach (backing[k]) golden[k] = backing[k];
        for (int i = 0; i < NL; i++) begin
            m_valid[i] = 1'b0;
            m_dirty[i] = 1'b0;
        end
        m_hits   = 0;
        m_misses = 0;
    endtask

    task automatic check_traffic(input string tag);
        int n;
        chk({tag, "_nxfer"}, 32'(obs_q.size()), 32'(exp_q.size()));
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            chk({tag, "_xaddr"}, 32'(obs_q[i].addr), 32'(exp_q[i].addr));
            chk({tag, "_xwe"}, 32'(obs_q[i].we), 32'(exp_q[i].we));
            if (exp_q[i].we) chk({tag, "_xdata"}, obs_q[i].data, exp_q[i].data);
        end
    endtask

    task automatic check_counters(input string tag);
        chk({tag, "_hits"}, bus.hit_count, 32'(m_hits));
        chk({tag, "_misses"}, bus.miss_count, 32'(m_misses));
    endtask

    // Called and returns at a negedge.
    task automatic do_op(input string tag, input bit we, input int a, input logic [31:0] wd);
        bit          exp_hit;
        logic [31:0] exp_rd;
        int          lat;
        obs_q.delete();
        exp_q.delete();
        model_access(we, a, wd, exp_hit, exp_rd);
        bus.cpu_we    = we;
        bus.cpu_addr  = ADDR_W'(a);
        bus.cpu_wdata = wd;
        bus.cpu_req   = 1'b1;
        lat = 0;
        while (lat < 3000) begin
            @(posedge clock);
            lat++;
            @(negedge clock);
            if (bus.cpu_ready) break;
        end
        chk({tag, "_ready"}, 32'(bus.cpu_ready), 32'd1);
        if (!we) chk({tag, "_rdata"}, bus.cpu_rdata, exp_rd);
        if (exp_hit) chk({tag, "_hitlat"}, 32'(lat), 32'd2);
        bus.cpu_req = 1'b0;
        @(posedge clock);
        @(negedge clock);
        chk({tag, "_pulse"}, 32'(bus.cpu_ready), 32'd0);
        check_counters(tag);
        check_traffic(tag);
    endtask

    task automatic do_flush(input string tag, input bit check_lat);
        int lat;
        obs_q.delete();
        exp_q.delete();
        model_flush();
        bus.flush = 1'b1;
        lat = 0;
        while (lat < 6000) begin
            @(posedge clock);
            lat++;
            @(negedge clock);
            bus.flush = 1'b0;
            if (bus.flush_done) break;
        end
        chk({tag, "_done"}, 32'(bus.flush_done), 32'd1);
        // scan of 64 clean lines: sampling edge + 64 scan edges before the pulse
        if (check_lat) chk({tag, "_lat"}, 32'(lat), 32'(NL + 1));
        @(posedge clock);
        @(negedge clock);
        chk({tag, "_pulse"}, 32'(bus.flush_done), 32'd0);
        check_counters(tag);
        check_traffic(tag);
    endtask

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin : main
        bit          h;
        logic [31:0] rd;
        int          lat, fd_at, rdy_at, nacks;
        bus.cpu_req   = 1'b0;
        bus.cpu_we    = 1'b0;
        bus.cpu_addr  = '0;
        bus.cpu_wdata = '0;
        bus.flush     = 1'b0;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = '0;
        reset = 1'b1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("rst_mem_req", 32'(bus.mem_req), 32'd0);
        chk("rst_ready", 32'(bus.cpu_ready), 32'd0);
        chk("rst_flush_done", 32'(bus.flush_done), 32'd0);
        chk("rst_hits", bus.hit_count, 32'd0);
        chk("rst_misses", bus.miss_count, 32'd0);
        chk("rst_rdata", bus.cpu_rdata, 32'd0);
        reset = 1'b0;

        // cold read miss: four ascending refill reads
        do_op("t1", 1'b0, 'h00014, 32'h0);
        chk("t1_nrd", 32'(obs_q.size()), 32'd4);
        for (int i = 0; i < 4 && i < obs_q.size(); i++)
            chk("t1_fill_addr", 32'(obs_q[i].addr), 32'h10 + 32'(4 * i));

        // same line: hit, no memory traffic
        do_op("t2", 1'b0, 'h00018, 32'h0);

        // dirty write hit, then conflicting read forces write-back then refill
        do_op("t3w", 1'b1, 'h00010, 32'hDEADBEEF);
        do_op("t3r", 1'b0, 'h00410, 32'h0);
        if (obs_q.size() >= 5) begin
            chk("t3_wb_addr", 32'(obs_q[0].addr), 32'h10);
            chk("t3_wb_data", obs_q[0].data, 32'hDEADBEEF);
            chk("t3_fill_addr", 32'(obs_q[4].addr), 32'h410);
        end else chk("t3_nxfer_min", 32'(obs_q.size()), 32'd8);

        // dirty lines at index 1 and 5, then flush twice
        do_op("t4a", 1'b1, 'h00414, 32'h12345678);
        do_op("t4b", 1'b1, 'h00054, 32'hCAFEF00D);
        do_flush("fl1", 1'b0);
        chk("fl1_nwr", 32'(obs_q.size()), 32'd8);
        do_flush("fl2", 1'b1);

        // flush and request together: flush goes first
        do_op("t5pre", 1'b1, 'h00C34, 32'hA5A5A5A5);
        obs_q.delete();
        exp_q.delete();
        model_flush();
        model_access(1'b0, 'h00C30, 32'h0, h, rd);
        bus.flush    = 1'b1;
        bus.cpu_req  = 1'b1;
        bus.cpu_we   = 1'b0;
        bus.cpu_addr = ADDR_W'('h00C30);
        fd_at = 0;
        rdy_at = 0;
        lat = 0;
        while (lat < 6000) begin
            @(posedge clock);
            lat++;
            @(negedge clock);
            bus.flush = 1'b0;
            if (bus.flush_done && fd_at == 0) fd_at = lat;
            if (bus.cpu_ready) begin
                rdy_at = lat;
                break;
            end
        end
        bus.cpu_req = 1'b0;
        chk("t5_flush_seen", 32'(fd_at != 0), 32'd1);
        chk("t5_order", 32'(fd_at != 0 && fd_at < rdy_at), 32'd1);
        chk("t5_rdata", bus.cpu_rdata, rd);
        @(posedge clock);
        @(negedge clock);
        check_counters("t5");
        check_traffic("t5");

        // reset in the middle of a refill burst
        obs_q.delete();
        bus.cpu_req  = 1'b1;
        bus.cpu_we   = 1'b0;
        bus.cpu_addr = ADDR_W'('h00824);
        nacks = 0;
        lat = 0;
        while (nacks < 2 && lat < 200) begin
            @(posedge clock);
            lat++;
            if (bus.mem_ack) nacks++;
        end
        chk("t6_two_acks", 32'(nacks), 32'd2);
        @(negedge clock);
        reset       = 1'b1;
        bus.cpu_req = 1'b0;
        @(posedge clock);
        @(negedge clock);
        chk("t6_mem_req", 32'(bus.mem_req), 32'd0);
        chk("t6_hits", bus.hit_count, 32'd0);
        chk("t6_misses", bus.miss_count, 32'd0);
        chk("t6_rdata", bus.cpu_rdata, 32'd0);
        reset = 1'b0;
        model_reset();
        do_op("t6re", 1'b0, 'h00824, 32'h0);
        chk("t6_nrd", 32'(obs_q.size()), 32'd4);

        // random accesses over a few colliding tags plus occasional flushes
        for (int n = 0; n < 400; n++) begin
            int a;
            a = $urandom_range(0, 3) * SPAN + $urandom_range(0, 7) * LB
              + $urandom_range(0, WPL - 1) * 4 + $urandom_range(0, 3);
            if ($urandom_range(0, 29) == 0) do_flush("rnd_flush", 1'b0);
            do_op("rnd", 1'($urandom_range(0, 1)), a, $urandom);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/wb_cache_ctrl.md
Name: wb_cache_ctrl

Overview:
- Synthesizable, parametrised direct-mapped, write-back, write-allocate data/instruction cache controller; successor of the current behavioural two-level cache model and its MEMbusy stall.
- Sits between one pipeline memory port (IF or MEM stage) and main memory.
- Adds a real request/ready handshake, multi-word line bursts, dirty-line write-back, explicit flush, and hit/miss counters.

Parameters:
- ADDR_W, 20: byte-address width (1 MiB main memory).
- NUM_LINES, 64: number of cache lines; power of two, at least 2.
- WORDS_PER_LINE, 4: 32-bit words per line; power of two, at least 1.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- cpu_req  in  1  access request; held with stable addr/we/wdata until cpu_ready
- cpu_we  in  1  1 = write word, 0 = read word
- cpu_addr  in  ADDR_W  byte address; bits [1:0] ignored (word aligned)
- cpu_wdata  in  32  write data
- cpu_rdata  out  32  read data, valid while cpu_ready=1
- cpu_ready  out  1  one-cycle completion pulse
- flush  in  1  write back all dirty lines
- flush_done  out  1  one-cycle pulse at flush end
- mem_req  out  1  memory word transfer request; held until mem_ack
- mem_we  out  1  1 = write to memory, 0 = read from memory
- mem_addr  out  ADDR_W  word-aligned memory byte address
- mem_wdata  out  32  write data to memory
- mem_rdata  in  32  read data, sampled on mem_ack
- mem_ack  in  1  completes one word transfer
- hit_count  out  32  first-lookup hits, wraps modulo 2^32
- miss_count  out  32  misses, wraps modulo 2^32

Behaviour:
- Address split (word-aligned byte address):
  - OFF = log2(WORDS_PER_LINE), IDX = log2(NUM_LINES).
  - word offset = addr[OFF+1:2]; index = addr[OFF+IDX+1:OFF+2]; tag = remaining upper bits.
  - Byte order is big-endian; words are stored whole.
- Per-line state: valid bit, dirty bit, tag, data words.
- States: IDLE, LOOKUP, WB, FILL, DONE, FLUSH.
- IDLE:
  - flush=1 → FLUSH, with flush taking priority over cpu_req.
  - else cpu_req=1 → latch addr/we/wdata, go to LOOKUP.
- LOOKUP (hit = valid && tag match):
  - Read hit: capture the word into cpu_rdata.
  - Write hit: write the word and set dirty.
  - After either hit → DONE.
  - Miss with valid && dirty → WB; miss otherwise → FILL.
  - hit_count increments only on a hit that was not preceded by a refill for this request.
  - miss_count increments once per request.
- WB:
  - Writes WORDS_PER_LINE words to {old_tag, index, w, 2'b00}, w = 0..N-1 ascending.
  - One word per mem_ack; mem_req stays asserted between words.
  - After the last ack → FILL.
- FILL:
  - Reads N words from {new_tag, index, w, 2'b00}, ascending.
  - Installs tag, valid=1, dirty=0.
  - After the last ack → LOOKUP, which is then guaranteed to hit.
- DONE:
  - cpu_ready=1 for exactly this cycle → IDLE.
  - The requester must drop or replace cpu_req by the following edge, otherwise the request is re-accepted.
- Hit latency: request sampled at edge n → cpu_ready high during cycle n+2.
- FLUSH:
  - Scans index 0..NUM_LINES-1, one cycle per clean or invalid line.
  - A valid dirty line gets a WB burst; dirty is cleared and valid is kept.
  - After the last line, flush_done=1 for one cycle → IDLE.
  - flush is ignored outside IDLE.
- mem_we/mem_addr/mem_wdata are stable while mem_req=1. mem_req=0 in IDLE, LOOKUP, DONE.
- mem_ack is ignored while mem_req=0.
- Reset, including mid-burst:
  - Next state IDLE; all valid and dirty bits cleared.
  - mem_req, cpu_ready, flush_done = 0; counters = 0; cpu_rdata = 0.
  - Any in-flight burst is abandoned and its dirty data is lost.
- No combinational path from cpu_* inputs to mem_* outputs; all outputs are registered.

Test Plan (NUM_LINES=64, WORDS_PER_LINE=4, memory model acks 2 cycles after each req):
1. After reset, read 0x00014 → four mem reads at 0x00010, 0x00014, 0x00018, 0x0001C; cpu_rdata = model word at 0x00014; miss_count=1, hit_count=0.
2. Then read 0x00018 → no mem_req; cpu_ready exactly 2 cycles after sampling; hit_count=1.
3. Write 0xDEADBEEF to 0x00010 (hit), then read 0x00410 (same index, different tag) → WB of 4 words starting at 0x00010 with first data 0xDEADBEEF, then FILL from 0x00410..0x0041C; miss_count=2.
4. Dirty lines at index 1 and 5, then flush → exactly 8 mem writes (index 1 words then index 5 words), one flush_done pulse. Second flush → zero mem writes, flush_done after 64 scan cycles.
5. flush and cpu_req asserted in the same IDLE cycle → flush completes first (flush_done), then the request completes with cpu_ready.
6. reset asserted during FILL after 2 acks → mem_req=0 next cycle, counters=0; re-read of the same address misses and refills all 4 words.
